// File: rtl/apb_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin APB arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int ProtWidth = 3;

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// Requester-side and APB-side signals of the arbiter, bundled with the arbiter
// as master and the requesters/APB slave environment as slave.
interface apb_rr_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int NumReq    = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic [NumReq-1:0]               reqValid;
  logic [NumReq-1:0]               reqWrite;
  logic [NumReq*AddrWidth-1:0]     reqAddr;
  logic [NumReq*DataWidth-1:0]     reqWData;
  logic [NumReq*DataWidth/8-1:0]   reqStrb;
  logic [NumReq*ProtWidth-1:0]     reqProt;
  logic [NumReq-1:0]               reqDone;
  logic [NumReq-1:0]               reqError;
  logic [DataWidth-1:0]            rData;

  logic                            psel;
  logic                            penable;
  logic                            pwrite;
  logic [AddrWidth-1:0]            paddr;
  logic [DataWidth-1:0]            pwdata;
  logic [DataWidth/8-1:0]          pstrb;
  logic [ProtWidth-1:0]            pprot;
  logic [DataWidth-1:0]            prdata;
  logic                            pready;
  logic                            pslverr;

  modport master (
    input  reqValid, reqWrite, reqAddr, reqWData, reqStrb, reqProt,
    input  prdata, pready, pslverr,
    output reqDone, reqError, rData,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );

  modport slave (
    output reqValid, reqWrite, reqAddr, reqWData, reqStrb, reqProt,
    output prdata, pready, pslverr,
    input  reqDone, reqError, rData,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );

endinterface

// File: rtl/apb_rr_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester after 'last', wrapping,
// found by rotating a doubled request vector and taking its lowest set bit.
module rr_picker #(
  parameter int NumReq = 4,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last,
  output logic              valid,
  output logic [IdxW-1:0]   index
);
  localparam int SumW = IdxW + 2;

  logic [2*NumReq-1:0] doubled;
  logic [NumReq-1:0]   rotated;
  logic [IdxW:0]       start;
  logic [IdxW-1:0]     offs;
  logic [SumW-1:0]     sum;

  assign doubled = {req, req};
  assign start   = {1'b0, last} + (IdxW+1)'(1);
  // start may equal NumReq, which selects the unrotated vector (wrap to 0)
  assign rotated = doubled[start +: NumReq];

  always_comb begin
    offs  = '0;
    valid = |rotated;
    for (int j = NumReq - 1; j >= 0; j--) begin
      if (rotated[j]) offs = IdxW'(j);
    end
    sum = {1'b0, start} + {2'b00, offs};
    if (sum >= SumW'(NumReq)) sum = sum - SumW'(NumReq);
    index = sum[IdxW-1:0];
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter granting NumReq requesters onto a single APB master port,
// one transfer at a time (IDLE -> SETUP -> ACCESS -> IDLE).
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NumReq    = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic              clk,
  input  logic              reset,
  apb_rr_arbiter_if.master  bus
);
  localparam int IdxW  = $clog2(NumReq);
  localparam int StrbW = DataWidth / 8;

  state_t state_reg, state_next;

  logic [IdxW-1:0]      last_grant_reg;
  logic                 pwrite_reg;
  logic [AddrWidth-1:0] paddr_reg;
  logic [DataWidth-1:0] pwdata_reg;
  logic [StrbW-1:0]     pstrb_reg;
  logic [ProtWidth-1:0] pprot_reg;
  logic [NumReq-1:0]    done_reg, done_next;
  logic [NumReq-1:0]    error_reg, error_next;
  logic [DataWidth-1:0] rdata_reg, rdata_next;

  logic [AddrWidth-1:0] addr_arr  [NumReq];
  logic [DataWidth-1:0] wdata_arr [NumReq];
  logic [StrbW-1:0]     strb_arr  [NumReq];
  logic [ProtWidth-1:0] prot_arr  [NumReq];

  logic [NumReq-1:0]    masked_req;
  logic                 pick_valid;
  logic [IdxW-1:0]      pick_idx;
  logic                 sel, en, grant, xfer_end;

  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.reqAddr[gi*AddrWidth +: AddrWidth];
      assign wdata_arr[gi] = bus.reqWData[gi*DataWidth +: DataWidth];
      assign strb_arr[gi]  = bus.reqStrb[gi*StrbW +: StrbW];
      assign prot_arr[gi]  = bus.reqProt[gi*ProtWidth +: ProtWidth];
    end
  endgenerate

  // A requester still holding reqValid in its done cycle must not win again
  assign masked_req = bus.reqValid & ~done_reg;

  rr_picker #(.NumReq(NumReq), .IdxW(IdxW)) u_picker (
    .req   (masked_req),
    .last  (last_grant_reg),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_valid) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (bus.pready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel        = 1'b0;
    en         = 1'b0;
    grant      = 1'b0;
    xfer_end   = 1'b0;
    case (state_reg)
      IDLE:    grant = pick_valid;
      SETUP:   sel = 1'b1;
      ACCESS: begin
        sel      = 1'b1;
        en       = 1'b1;
        xfer_end = bus.pready;
      end
      default: ;
    endcase
    done_next  = '0;
    error_next = '0;
    rdata_next = rdata_reg;
    // last_grant_reg doubles as the index of the requester currently on the bus
    if (xfer_end) begin
      done_next[last_grant_reg]  = 1'b1;
      error_next[last_grant_reg] = bus.pslverr;
      if (!pwrite_reg) rdata_next = bus.prdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= IdxW'(NumReq - 1);
      pwrite_reg     <= 1'b0;
      paddr_reg      <= '0;
      pwdata_reg     <= '0;
      pstrb_reg      <= '0;
      pprot_reg      <= '0;
      done_reg       <= '0;
      error_reg      <= '0;
      rdata_reg      <= '0;
    end else begin
      done_reg  <= done_next;
      error_reg <= error_next;
      rdata_reg <= rdata_next;
      if (grant) begin
        last_grant_reg <= pick_idx;
        pwrite_reg     <= bus.reqWrite[pick_idx];
        paddr_reg      <= addr_arr[pick_idx];
        pwdata_reg     <= wdata_arr[pick_idx];
        pstrb_reg      <= strb_arr[pick_idx];
        pprot_reg      <= prot_arr[pick_idx];
      end
    end
  end

  assign bus.psel     = sel;
  assign bus.penable  = en;
  assign bus.pwrite   = pwrite_reg;
  assign bus.paddr    = paddr_reg;
  assign bus.pwdata   = pwdata_reg;
  assign bus.pstrb    = pstrb_reg;
  assign bus.pprot    = pprot_reg;
  assign bus.reqDone  = done_reg;
  assign bus.reqError = error_reg;
  assign bus.rData    = rdata_reg;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter: directed transfer table, hand-written corner
// sequences, then random traffic against a transaction-level reference model.
module tb_apb_rr_arbiter;
  import apb_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  apb_rr_arbiter_if #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) bus();

  apb_rr_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [N-1:0]  r_valid;
  logic [N-1:0]  r_write;
  logic [AW-1:0] r_addr  [N];
  logic [DW-1:0] r_wdata [N];
  logic [SW-1:0] r_strb  [N];
  logic [2:0]    r_prot  [N];

  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prd;
    int          waits;
    logic        slverr;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_cycles;
    int          exp_pen;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      bus.reqAddr[i*AW +: AW]  = r_addr[i];
      bus.reqWData[i*DW +: DW] = r_wdata[i];
      bus.reqStrb[i*SW +: SW]  = r_strb[i];
      bus.reqProt[i*3 +: 3]    = r_prot[i];
    end
    bus.reqValid = r_valid;
    bus.reqWrite = r_write;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    r_valid = '0;
    drive_bus();
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic int rr_pick(input logic [N-1:0] pend, input int last);
    int cand;
    for (int k = 1; k <= N; k++) begin
      cand = (last + k) % N;
      if (pend[cand]) return cand;
    end
    return -1;
  endfunction

  task automatic run_single(input vec_t v);
    int t = 0;
    int pen = 0;
    int done_t = -1;
    logic [N-1:0]  dvec = '0;
    logic [N-1:0]  evec = '0;
    logic [N-1:0]  onehot = '0;
    logic [N-1:0]  exp_evec = '0;
    logic [31:0]   drd = '0;
    logic [31:0]   seen_addr = '0;
    logic          seen_wr = 1'b0;
    r_addr[v.idx]  = v.addr;
    r_wdata[v.idx] = v.wdata;
    r_write[v.idx] = v.wr;
    r_strb[v.idx]  = '1;
    r_prot[v.idx]  = 3'(v.idx);
    r_valid        = '0;
    r_valid[v.idx] = 1'b1;
    drive_bus();
    while (done_t < 0 && t < 30) begin
      @(negedge clk);
      t++;
      if (bus.reqDone != '0) begin
        done_t = t;
        dvec = bus.reqDone;
        evec = bus.reqError;
        drd  = bus.rData;
        r_valid = '0;
        drive_bus();
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
      end else if (bus.psel && bus.penable) begin
        pen++;
        seen_addr = bus.paddr;
        seen_wr   = bus.pwrite;
        if (pen <= v.waits) begin
          bus.pready  = 1'b0;
          bus.pslverr = 1'b1;
          bus.prdata  = 32'hBAD0_0000 | 32'(pen);
        end else begin
          bus.pready  = 1'b1;
          bus.pslverr = v.slverr;
          bus.prdata  = v.prd;
        end
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
      end
    end
    onehot[v.idx]   = 1'b1;
    exp_evec[v.idx] = v.exp_err;
    check("vec_latency", 64'(done_t), 64'(v.exp_cycles));
    check("vec_penable_cycles", 64'(pen), 64'(v.exp_pen));
    check("vec_done", 64'(dvec), 64'(onehot));
    check("vec_error", 64'(evec), 64'(exp_evec));
    check("vec_rdata", 64'(drd), 64'(v.exp_rdata));
    check("vec_paddr", 64'(seen_addr), 64'(v.addr));
    check("vec_pwrite", 64'(seen_wr), 64'(v.wr));
    $display("vec req=%0d wr=%0d addr=0x%0h cycles=%0d done=%b err=%b rdata=0x%0h",
             v.idx, v.wr, v.addr, done_t, dvec, evec, drd);
    @(negedge clk);
  endtask

  initial begin
    int order [$];
    int fair_exp [5];
    int found;
    int model_last;
    int phase;
    int winner;
    logic [N-1:0]  prev_pend;
    logic [N-1:0]  exp_done;
    logic [N-1:0]  exp_err_v;
    logic          prev_ready;
    logic          prev_err;
    logic [31:0]   prev_prd;
    logic [31:0]   model_rdata;

    fair_exp = '{0, 1, 2, 3, 0};
    r_valid = '0;
    r_write = '0;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = '0; r_wdata[i] = '0; r_strb[i] = '0; r_prot[i] = '0;
    end
    drive_bus();
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = '0;

    vecs[0] = '{idx:2, wr:1'b1, addr:32'h40,  wdata:32'hDEADBEEF, prd:32'h0,        waits:0, slverr:1'b0,
                exp_err:1'b0, exp_rdata:32'h0,        exp_cycles:3, exp_pen:1};
    vecs[1] = '{idx:1, wr:1'b0, addr:32'h100, wdata:32'h0,        prd:32'h1234,     waits:3, slverr:1'b0,
                exp_err:1'b0, exp_rdata:32'h1234,     exp_cycles:6, exp_pen:4};
    vecs[2] = '{idx:3, wr:1'b1, addr:32'h80,  wdata:32'h55,       prd:32'hFFFF0000, waits:2, slverr:1'b1,
                exp_err:1'b1, exp_rdata:32'h1234,     exp_cycles:5, exp_pen:3};
    vecs[3] = '{idx:0, wr:1'b0, addr:32'h200, wdata:32'h0,        prd:32'hCAFEF00D, waits:1, slverr:1'b0,
                exp_err:1'b0, exp_rdata:32'hCAFEF00D, exp_cycles:4, exp_pen:2};
    vecs[4] = '{idx:2, wr:1'b0, addr:32'h44,  wdata:32'h0,        prd:32'hA5A5A5A5, waits:0, slverr:1'b1,
                exp_err:1'b1, exp_rdata:32'hA5A5A5A5, exp_cycles:3, exp_pen:1};
    vecs[5] = '{idx:1, wr:1'b1, addr:32'h104, wdata:32'h0BADF00D, prd:32'h11111111, waits:0, slverr:1'b0,
                exp_err:1'b0, exp_rdata:32'hA5A5A5A5, exp_cycles:3, exp_pen:1};

    // reset state, sampled while reset is still held
    @(negedge clk);
    @(negedge clk);
    check("rst_psel", 64'(bus.psel), 64'(0));
    check("rst_penable", 64'(bus.penable), 64'(0));
    check("rst_pwrite", 64'(bus.pwrite), 64'(0));
    check("rst_paddr", 64'(bus.paddr), 64'(0));
    check("rst_pwdata", 64'(bus.pwdata), 64'(0));
    check("rst_pstrb", 64'(bus.pstrb), 64'(0));
    check("rst_pprot", 64'(bus.pprot), 64'(0));
    check("rst_done", 64'(bus.reqDone), 64'(0));
    check("rst_error", 64'(bus.reqError), 64'(0));
    check("rst_rdata", 64'(bus.rData), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) run_single(vecs[v]);

    // fairness: everyone requests continuously from reset
    do_reset();
    for (int i = 0; i < N; i++) begin
      r_addr[i]  = 32'h1000 + 32'(i * 16);
      r_write[i] = 1'b1;
      r_wdata[i] = 32'(i);
    end
    r_valid = '1;
    drive_bus();
    bus.pready  = 1'b1;
    bus.pslverr = 1'b0;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      @(negedge clk);
      if (bus.psel && !bus.penable) begin
        order.push_back(int'((bus.paddr - 32'h1000) / 16));
        $display("fair grant #%0d -> req %0d", order.size(), order[order.size()-1]);
      end
    end
    check("fair_grant_count", 64'(order.size()), 64'(5));
    for (int k = 0; k < 5; k++) begin
      if (k < order.size()) check("fair_order", 64'(order[k]), 64'(fair_exp[k]));
      else check("fair_order_missing", 64'(k), 64'(order.size()));
    end

    // masking: sole requester 0 keeps reqValid through its done cycle
    do_reset();
    r_addr[0] = 32'h2000;
    r_write   = '0;
    r_valid   = 4'b0001;
    drive_bus();
    bus.pready = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk);
      if (bus.reqDone[0]) found = 1;
    end
    check("mask_first_done", 64'(found), 64'(1));
    @(negedge clk);
    check("mask_no_regrant", 64'(bus.psel), 64'(0));
    @(negedge clk);
    check("mask_regrant_psel", 64'({bus.psel, bus.penable}), 64'(2'b10));
    check("mask_regrant_addr", 64'(bus.paddr), 64'(32'h2000));
    $display("mask seq: req 0 re-granted one cycle after its done cycle");

    // reset while ACCESS is stalled
    do_reset();
    r_addr[1] = 32'h3000;
    r_valid   = 4'b0010;
    drive_bus();
    bus.pready = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      if (bus.psel && bus.penable) found = 1;
    end
    check("rst_acc_reached", 64'(found), 64'(1));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_acc_psel_pen", 64'({bus.psel, bus.penable}), 64'(0));
    check("rst_acc_done", 64'(bus.reqDone), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    r_addr[0] = 32'h4000;
    r_addr[2] = 32'h4200;
    r_valid   = 4'b0101;
    drive_bus();
    @(negedge clk);
    check("rst_acc_regrant_psel", 64'({bus.psel, bus.penable}), 64'(2'b10));
    check("rst_acc_regrant_addr", 64'(bus.paddr), 64'(32'h4000));
    check("rst_acc_no_done", 64'(bus.reqDone), 64'(0));
    $display("reset-in-access seq: first grant after reset to paddr=0x%0h", bus.paddr);

    // random traffic against transaction-level model
    do_reset();
    model_last  = N - 1;
    phase       = 0;
    winner      = 0;
    prev_pend   = '0;
    prev_ready  = 1'b0;
    prev_err    = 1'b0;
    prev_prd    = '0;
    model_rdata = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      exp_done  = '0;
      exp_err_v = '0;
      case (phase)
        0: begin
          if (prev_pend != '0) begin
            winner = rr_pick(prev_pend, model_last);
            model_last = winner;
            check("rnd_setup", 64'({bus.psel, bus.penable}), 64'(2'b10));
            check("rnd_paddr", 64'(bus.paddr), 64'(r_addr[winner]));
            check("rnd_pwrite", 64'(bus.pwrite), 64'(r_write[winner]));
            check("rnd_pwdata", 64'(bus.pwdata), 64'(r_wdata[winner]));
            check("rnd_pstrb", 64'(bus.pstrb), 64'(r_strb[winner]));
            check("rnd_pprot", 64'(bus.pprot), 64'(r_prot[winner]));
            phase = 1;
          end else begin
            check("rnd_idle", 64'({bus.psel, bus.penable}), 64'(0));
          end
        end
        1: begin
          check("rnd_access", 64'({bus.psel, bus.penable}), 64'(2'b11));
          check("rnd_access_addr", 64'(bus.paddr), 64'(r_addr[winner]));
          phase = 2;
        end
        default: begin
          if (prev_ready) begin
            check("rnd_return_idle", 64'(bus.psel), 64'(0));
            exp_done[winner]  = 1'b1;
            exp_err_v[winner] = prev_err;
            if (!r_write[winner]) model_rdata = prev_prd;
            check("rnd_error", 64'(bus.reqError), 64'(exp_err_v));
            $display("rnd txn req=%0d wr=%0d addr=0x%0h err=%0d rdata=0x%0h",
                     winner, r_write[winner], r_addr[winner], prev_err, model_rdata);
            phase = 0;
          end else begin
            check("rnd_wait_hold", 64'({bus.psel, bus.penable}), 64'(2'b11));
            check("rnd_wait_addr", 64'(bus.paddr), 64'(r_addr[winner]));
          end
        end
      endcase
      check("rnd_done", 64'(bus.reqDone), 64'(exp_done));
      check("rnd_rdata", 64'(bus.rData), 64'(model_rdata));

      for (int i = 0; i < N; i++) begin
        if (exp_done[i] || !r_valid[i]) begin
          if ((exp_done[i] && $urandom_range(0, 1) == 1) ||
              (!r_valid[i] && !exp_done[i] && $urandom_range(0, 3) == 0)) begin
            r_valid[i] = 1'b1;
            r_write[i] = 1'($urandom_range(0, 1));
            r_addr[i]  = $urandom;
            r_wdata[i] = $urandom;
            r_strb[i]  = SW'($urandom);
            r_prot[i]  = 3'($urandom);
          end else begin
            r_valid[i] = 1'b0;
          end
        end
      end
      drive_bus();
      bus.pready  = ($urandom_range(0, 2) != 0);
      bus.pslverr = ($urandom_range(0, 3) == 0);
      bus.prdata  = $urandom;
      prev_ready  = bus.pready;
      prev_err    = bus.pslverr;
      prev_prd    = bus.prdata;
      prev_pend   = r_valid & ~exp_done;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
